mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single DRAM port shared by instruction fetch and the load/store unit. It accepts one request at a time from either requester and drives the DRAM port. It tracks the single outstanding transaction and routes the DRAM response back to its owner. Data accesses have priority; an optional starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STREAK_MAX, 4, max consecutive LSU grants while fetch waits (starvation guard only); legal 1..15

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_ip  in  1  fetch request; held until if_gnt_op
- if_addr_ip  in  ADDR_W  fetch address
- if_flush_ip  in  1  fetch redirect; cancels any outstanding fetch response
- if_gnt_op  out  1  fetch request accepted this cycle
- if_rvalid_op  out  1  fetch data valid, 1-cycle pulse
- if_rdata_op  out  DATA_W  fetch data
- lsu_req_ip  in  1  LSU request; held until lsu_gnt_op
- lsu_we_ip  in  1  1 = store, 0 = load
- lsu_addr_ip  in  ADDR_W  data address
- lsu_wdata_ip  in  DATA_W  store data
- lsu_gnt_op  out  1  LSU request accepted this cycle
- lsu_rvalid_op  out  1  load data / store ack, 1-cycle pulse
- lsu_rdata_op  out  DATA_W  load data (0 for stores)
- mem_req_op  out  1  DRAM request, 1-cycle pulse
- mem_we_op  out  1  DRAM write enable
- mem_addr_op  out  ADDR_W  DRAM address
- mem_wdata_op  out  DATA_W  DRAM write data
- mem_rvalid_ip  in  1  DRAM response (read data or write done)
- mem_rdata_ip  in  DATA_W  DRAM read data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LSU, BUSY_DROP.
- IDLE, no request: all request/grant outputs 0.
- IDLE, request present: winner selected combinationally. In the same cycle the arbiter:
  - asserts the winner's gnt;
  - asserts mem_req_op;
  - muxes the winner's addr/we/wdata onto mem_*.
- Fetch grants always have mem_we_op = 0.
- State transitions on a grant: next state is BUSY_IF or BUSY_LSU.
- Arbitration: LSU wins over fetch, except when the guard forces fetch (see Configuration).
- BUSY_x with mem_rvalid_ip:
  - if_rvalid_op or lsu_rvalid_op pulses combinationally in that cycle.
  - Data passes through from mem_rdata_ip.
  - Next state is IDLE.
  - No new grant in a BUSY cycle; one bubble after each response is mandatory.
- if_flush_ip in BUSY_IF without rvalid: next state is BUSY_DROP.
- if_flush_ip in the same cycle as the fetch rvalid: if_rvalid_op is suppressed and next state is IDLE.
- BUSY_DROP: waits for mem_rvalid_ip, discards it (no rvalid to either requester), then goes to IDLE.
- if_flush_ip in IDLE with if_req_ip high: the fetch still arbitrates normally. The fetch unit owns dropping its request.
- if_flush_ip has no effect on BUSY_LSU.
- Unused rdata outputs are driven 0 when their rvalid is low.
- A mem_rvalid_ip in IDLE is ignored (protocol error, no state change).

## Timing
- Reset (async, reset = 0): state IDLE, all outputs 0, streak counter 0.
- Grant latency: 0 cycles from req in IDLE.
- Response latency: DRAM latency + 0. The total transaction is ≥ 2 cycles plus 1 idle bubble.
- Back-to-back requests from a single requester: gnt at T, rvalid at T+L, next gnt at T+L+1.
- Reset asserted mid-transaction aborts it. A late mem_rvalid_ip after reset release is ignored (IDLE rule).

## Configuration
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit streak counter increments on each LSU grant made while if_req_ip = 1.
  - It clears on any fetch grant, and on any LSU grant made while if_req_ip = 0.
  - When streak = STREAK_MAX and both requesters are present, fetch wins.
- Undefined:
  - Strict LSU priority.
  - No counter is instantiated.
  - Fetch can starve indefinitely.

## Test plan
- Single fetch, DRAM latency 2:
  - if_req at T, addr 0x10 -> if_gnt and mem_req at T, mem_we = 0.
  - rdata 0xDEADBEEF at T+2 -> if_rvalid at T+2.
- Simultaneous requests, lsu_we = 1, addr 0x200, wdata 0x55 -> lsu_gnt first.
  - mem_we = 1, mem_addr = 0x200.
  - lsu_rvalid on DRAM ack, lsu_rdata = 0.
  - if_gnt one cycle after the LSU response.
- Flush during BUSY_IF:
  - fetch outstanding, if_flush pulse, DRAM response 1 cycle later -> no if_rvalid.
  - State returns to IDLE and the next request is granted normally.
- Guard on, STREAK_MAX = 4, both requesters held continuously -> grant order L,L,L,L,F,L,L,L,L,F.
- Guard off, same stimulus -> only LSU grants; if_gnt never asserts.
- Reset asserted in BUSY_LSU -> all outputs 0 immediately. A subsequent mem_rvalid_ip in IDLE produces no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one DRAM port between instruction fetch and the LSU, one
//           transaction in flight, response routed back to its owner.
// Latency : grant 0 cycles from request in IDLE; response = DRAM latency + 0;
//           one mandatory idle bubble after every response.
// Backpressure: requesters hold req until gnt; no grant while a transaction is
//           outstanding; the DRAM side has no stall (single outstanding only).
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard (4-bit LSU streak counter, fetch forced after STREAK_MAX
// consecutive LSU wins while fetch waits). Undefined: strict LSU priority.
//
// Ports:
//   clock / reset          : rising-edge clock, asynchronous active-low reset
//   if_req_ip/if_addr_ip   : fetch request, held until if_gnt_op
//   if_flush_ip            : fetch redirect, cancels an outstanding fetch reply
//   if_gnt_op/if_rvalid_op/if_rdata_op : fetch grant, reply pulse and data
//   lsu_req_ip/we/addr/wdata : LSU request, held until lsu_gnt_op
//   lsu_gnt_op/lsu_rvalid_op/lsu_rdata_op : LSU grant, reply pulse, load data
//   mem_req_op/we/addr/wdata : DRAM request (1-cycle pulse)
//   mem_rvalid_ip/mem_rdata_ip : DRAM reply (read data or write done)

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  // fetch requester
  input  logic              if_req_ip,
  input  logic [ADDR_W-1:0] if_addr_ip,
  input  logic              if_flush_ip,
  output logic              if_gnt_op,
  output logic              if_rvalid_op,
  output logic [DATA_W-1:0] if_rdata_op,
  // load/store requester
  input  logic              lsu_req_ip,
  input  logic              lsu_we_ip,
  input  logic [ADDR_W-1:0] lsu_addr_ip,
  input  logic [DATA_W-1:0] lsu_wdata_ip,
  output logic              lsu_gnt_op,
  output logic              lsu_rvalid_op,
  output logic [DATA_W-1:0] lsu_rdata_op,
  // DRAM port
  output logic              mem_req_op,
  output logic              mem_we_op,
  output logic [ADDR_W-1:0] mem_addr_op,
  output logic [DATA_W-1:0] mem_wdata_op,
  input  logic              mem_rvalid_ip,
  input  logic [DATA_W-1:0] mem_rdata_ip
);

  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_streak_max_range
    $error("mem_port_arbiter: STREAK_MAX must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_IF   = 2'd1,
    BUSY_LSU  = 2'd2,
    BUSY_DROP = 2'd3
  } state_e;

  state_e state_q;
  logic   lsu_we_q;     // outstanding LSU transaction is a store

  logic   in_idle;
  logic   force_if;     // starvation guard overrides LSU priority
  logic   grant_if;
  logic   grant_lsu;
  logic   rsp_if;
  logic   rsp_lsu;

  assign in_idle = (state_q == IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  // Counts LSU wins that happened while fetch was waiting.
  logic [3:0] streak_q;

  assign force_if = if_req_ip && lsu_req_ip && (streak_q == STREAK_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak_q <= 4'd0;
    end else if (grant_if) begin
      streak_q <= 4'd0;
    end else if (grant_lsu) begin
      streak_q <= if_req_ip ? streak_q + 4'd1 : 4'd0;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants and responses are combinational; gating with reset keeps every
  // output at 0 for the whole time reset is held, even with requests present.
  assign grant_lsu = reset && in_idle && lsu_req_ip && !force_if;
  assign grant_if  = reset && in_idle && if_req_ip && (!lsu_req_ip || force_if);

  // A flush arriving together with the fetch reply swallows that reply.
  assign rsp_if  = reset && (state_q == BUSY_IF) && mem_rvalid_ip && !if_flush_ip;
  assign rsp_lsu = reset && (state_q == BUSY_LSU) && mem_rvalid_ip;

  // Request side
  assign if_gnt_op    = grant_if;
  assign lsu_gnt_op   = grant_lsu;
  assign mem_req_op   = grant_if || grant_lsu;
  assign mem_we_op    = grant_lsu && lsu_we_ip;
  assign mem_addr_op  = grant_lsu ? lsu_addr_ip :
                        grant_if  ? if_addr_ip  : '0;
  assign mem_wdata_op = grant_lsu ? lsu_wdata_ip : '0;

  // Response side; rdata is zero whenever its rvalid is low, and a store
  // acknowledgement carries no data.
  assign if_rvalid_op  = rsp_if;
  assign if_rdata_op   = rsp_if ? mem_rdata_ip : '0;
  assign lsu_rvalid_op = rsp_lsu;
  assign lsu_rdata_op  = (rsp_lsu && !lsu_we_q) ? mem_rdata_ip : '0;

  // Transaction sequencer. A response always returns to IDLE, so the cycle
  // carrying the response can never also carry a grant (the idle bubble).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lsu_we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // mem_rvalid_ip here is a protocol error and is ignored.
          if (grant_lsu) begin
            state_q  <= BUSY_LSU;
            lsu_we_q <= lsu_we_ip;
          end else if (grant_if) begin
            state_q  <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_rvalid_ip) begin
            state_q <= IDLE;
          end else if (if_flush_ip) begin
            state_q <= BUSY_DROP;
          end
        end
        BUSY_LSU: begin
          if (mem_rvalid_ip) begin
            state_q <= IDLE;
          end
        end
        BUSY_DROP: begin
          // Fetch was redirected; the stale reply is discarded here.
          if (mem_rvalid_ip) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req_ip, if_flush_ip, if_gnt_op, if_rvalid_op;
  logic [ADDR_W-1:0] if_addr_ip;
  logic [DATA_W-1:0] if_rdata_op;
  logic              lsu_req_ip, lsu_we_ip, lsu_gnt_op, lsu_rvalid_op;
  logic [ADDR_W-1:0] lsu_addr_ip;
  logic [DATA_W-1:0] lsu_wdata_ip, lsu_rdata_op;
  logic              mem_req_op, mem_we_op, mem_rvalid_ip;
  logic [ADDR_W-1:0] mem_addr_op;
  logic [DATA_W-1:0] mem_wdata_op, mem_rdata_ip;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_flush_ip(if_flush_ip),
    .if_gnt_op(if_gnt_op), .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op),
    .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_addr_ip(lsu_addr_ip),
    .lsu_wdata_ip(lsu_wdata_ip), .lsu_gnt_op(lsu_gnt_op), .lsu_rvalid_op(lsu_rvalid_op),
    .lsu_rdata_op(lsu_rdata_op), .mem_req_op(mem_req_op), .mem_we_op(mem_we_op),
    .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op),
    .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip)
  );

  typedef struct { logic is_lsu; logic [31:0] addr; logic we; logic [31:0] wdata; } gnt_t;
  typedef struct { logic is_lsu; logic [31:0] data; } rsp_t;

  gnt_t  gnt_q[$];
  rsp_t  rsp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    log_en   = 1'b0;
  string grant_log = "";

  // stimulus knobs
  int p_if = 0, p_lsu = 0, p_flush = 0, p_stray = 0;
  int lat_min = 1, lat_max = 1, flush_at = -1;
  bit fix_data = 1'b0;
  logic [31:0] fix_val = 32'h0;

  // transaction-level reference model
  bit          if_pend = 0, lsu_pend = 0, lsu_w = 0;
  logic [31:0] if_a = 0, lsu_a = 0, lsu_d = 0;
  bit          out_v = 0, out_lsu = 0, out_we = 0, out_drop = 0;
  int          out_age = 0, out_lat = 0, streak = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // One clock cycle of stimulus; expectations are pushed as they are decided.
  task automatic step();
    bit flush, win_lsu;
    @(posedge clock); #1;
    mem_rvalid_ip = 1'b0;
    mem_rdata_ip  = $urandom;
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1; if_a = $urandom;
    end
    if (!lsu_pend && $urandom_range(99) < p_lsu) begin
      lsu_pend = 1; lsu_w = 1'($urandom_range(1)); lsu_a = $urandom; lsu_d = $urandom;
    end
    if (out_v) out_age++;
    if (flush_at >= 0) flush = out_v && !out_lsu && (out_age == flush_at);
    else               flush = ($urandom_range(99) < p_flush);
    if_flush_ip  = flush;
    if_req_ip    = if_pend;
    if_addr_ip   = if_a;
    lsu_req_ip   = lsu_pend;
    lsu_we_ip    = lsu_w;
    lsu_addr_ip  = lsu_a;
    lsu_wdata_ip = lsu_d;
    if (out_v) begin
      if (out_age == out_lat) begin
        mem_rvalid_ip = 1'b1;
        if (fix_data) mem_rdata_ip = fix_val;
        if (out_lsu) rsp_q.push_back('{1'b1, out_we ? 32'h0 : mem_rdata_ip});
        else if (!out_drop && !flush) rsp_q.push_back('{1'b0, mem_rdata_ip});
        out_v = 0;
      end else if (!out_lsu && flush) begin
        out_drop = 1;
      end
    end else begin
      if ($urandom_range(99) < p_stray) mem_rvalid_ip = 1'b1;
      if (if_pend || lsu_pend) begin
        win_lsu = lsu_pend && !(GUARD && if_pend && streak == STREAK_MAX);
        if (win_lsu) begin
          gnt_q.push_back('{1'b1, lsu_a, lsu_w, lsu_d});
          streak   = if_pend ? streak + 1 : 0;
          lsu_pend = 0;
          out_we   = lsu_w;
        end else begin
          gnt_q.push_back('{1'b0, if_a, 1'b0, 32'h0});
          streak  = 0;
          if_pend = 0;
        end
        out_v = 1; out_lsu = win_lsu; out_drop = 0; out_age = 0;
        out_lat = $urandom_range(lat_max, lat_min);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((out_v || if_pend || lsu_pend) && n < 200) begin
      step();
      n++;
    end
    if (out_v || if_pend || lsu_pend) note_fail("drain_timeout", "model never went idle");
    step();
  endtask

  // Monitor / scoreboard
  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clock);
      check("gnt_vs_mem_req", 64'(if_gnt_op | lsu_gnt_op), 64'(mem_req_op));
      check("gnt_onehot", 64'(if_gnt_op & lsu_gnt_op), 64'd0);
      if (mem_req_op) begin
        if (gnt_q.size() == 0) note_fail("unexpected_grant", "mem_req_op with no grant expected");
        else begin
          g = gnt_q.pop_front();
          check("gnt_owner_lsu", 64'(lsu_gnt_op), 64'(g.is_lsu));
          check("mem_addr", 64'(mem_addr_op), 64'(g.addr));
          check("mem_we", 64'(mem_we_op), 64'(g.we));
          if (g.is_lsu) check("mem_wdata", 64'(mem_wdata_op), 64'(g.wdata));
        end
        if (log_en) grant_log = {grant_log, lsu_gnt_op ? "L" : "F"};
      end else if (gnt_q.size() != 0) begin
        g = gnt_q.pop_front();
        note_fail("missing_grant", "expected grant did not occur");
      end
      check("rvalid_onehot", 64'(if_rvalid_op & lsu_rvalid_op), 64'd0);
      if (if_rvalid_op || lsu_rvalid_op) begin
        if (rsp_q.size() == 0) note_fail("unexpected_rvalid", "response with none expected");
        else begin
          r = rsp_q.pop_front();
          check("rsp_owner_lsu", 64'(lsu_rvalid_op), 64'(r.is_lsu));
          check("rsp_data", 64'(r.is_lsu ? lsu_rdata_op : if_rdata_op), 64'(r.data));
        end
      end else if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        note_fail("missing_rvalid", "expected response did not occur");
      end
      if (!if_rvalid_op)  check("if_rdata_idle", 64'(if_rdata_op), 64'd0);
      if (!lsu_rvalid_op) check("lsu_rdata_idle", 64'(lsu_rdata_op), 64'd0);
    end
  end

  // Stimulus
  initial begin
    string exp_seq;
    int    n;
    reset = 1'b0;
    if_req_ip = 1; if_addr_ip = 32'h4; if_flush_ip = 0;
    lsu_req_ip = 1; lsu_we_ip = 1; lsu_addr_ip = 32'h8; lsu_wdata_ip = 32'h9;
    mem_rvalid_ip = 0; mem_rdata_ip = 0;
    #12;
    check("rst_if_gnt", 64'(if_gnt_op), 64'd0);
    check("rst_lsu_gnt", 64'(lsu_gnt_op), 64'd0);
    check("rst_mem_req", 64'(mem_req_op), 64'd0);
    check("rst_mem_we", 64'(mem_we_op), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_op), 64'd0);
    if_req_ip = 0; lsu_req_ip = 0; lsu_we_ip = 0;
    @(negedge clock);
    reset = 1'b1;

    // single fetch, DRAM latency 2
    lat_min = 2; lat_max = 2; fix_data = 1; fix_val = 32'hDEADBEEF;
    if_pend = 1; if_a = 32'h10;
    drain();
    fix_data = 0;

    // simultaneous requests: LSU store first, then fetch after the bubble
    lat_min = 1; lat_max = 3;
    if_pend = 1; if_a = 32'h40;
    lsu_pend = 1; lsu_w = 1; lsu_a = 32'h200; lsu_d = 32'h55;
    drain();

    // flush during BUSY_IF (reply one cycle later), then flush with the reply
    lat_min = 2; lat_max = 2; flush_at = 1;
    if_pend = 1; if_a = 32'h80;
    drain();
    flush_at = 2;
    if_pend = 1; if_a = 32'h88;
    drain();
    flush_at = -1;
    if_pend = 1; if_a = 32'h84;
    drain();

    // both requesters held continuously
    lat_min = 1; lat_max = 3; p_if = 100; p_lsu = 100;
    grant_log = ""; log_en = 1; n = 0;
    while (grant_log.len() < 10 && n < 300) begin
      step();
      n++;
    end
    log_en = 0; p_if = 0; p_lsu = 0;
    drain();
    exp_seq = GUARD ? "LLLLFLLLLF" : "LLLLLLLLLL";
    if (grant_log.len() < 10) note_fail("grant_order_timeout", "fewer than 10 grants seen");
    else for (int i = 0; i < 10; i++) check("grant_order", 64'(grant_log[i]), 64'(exp_seq[i]));

    // randomized traffic with flushes and stray DRAM replies
    lat_min = 1; lat_max = 4; p_if = 40; p_lsu = 40; p_flush = 10; p_stray = 5;
    for (int i = 0; i < 2000; i++) step();
    p_if = 0; p_lsu = 0; p_flush = 0; p_stray = 0;
    drain();

    // reset in BUSY_LSU
    lat_min = 6; lat_max = 6;
    lsu_pend = 1; lsu_w = 0; lsu_a = 32'h300; lsu_d = 32'h0;
    step();
    step();
    @(posedge clock); #1;
    reset = 1'b0;
    if_req_ip = 1; lsu_req_ip = 1; lsu_we_ip = 1; mem_rvalid_ip = 1; if_flush_ip = 0;
    #1;
    check("rst_busy_if_gnt", 64'(if_gnt_op), 64'd0);
    check("rst_busy_lsu_gnt", 64'(lsu_gnt_op), 64'd0);
    check("rst_busy_mem_req", 64'(mem_req_op), 64'd0);
    check("rst_busy_mem_we", 64'(mem_we_op), 64'd0);
    check("rst_busy_mem_addr", 64'(mem_addr_op), 64'd0);
    check("rst_busy_mem_wdata", 64'(mem_wdata_op), 64'd0);
    check("rst_busy_lsu_rvalid", 64'(lsu_rvalid_op), 64'd0);
    check("rst_busy_lsu_rdata", 64'(lsu_rdata_op), 64'd0);
    check("rst_busy_if_rvalid", 64'(if_rvalid_op), 64'd0);
    gnt_q.delete(); rsp_q.delete();
    out_v = 0; if_pend = 0; lsu_pend = 0; streak = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    if_req_ip = 0; lsu_req_ip = 0;
    mem_rvalid_ip = 1; mem_rdata_ip = $urandom;
    #1;
    check("late_rvalid_if", 64'(if_rvalid_op), 64'd0);
    check("late_rvalid_lsu", 64'(lsu_rvalid_op), 64'd0);
    lat_min = 1; lat_max = 2;
    if_pend = 1; if_a = 32'h100;
    drain();

    @(negedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
